// File: rtl/counter_pkg.sv
// Shared definitions for the counting primitives: mode selectors and a
// helper that sizes a counter for a given modulus.
package counter_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    // Smallest register width able to hold 0..modulus-1 (never below 1 bit).
    function automatic int min_width(input int modulus);
        return (modulus <= 2) ? 1 : $clog2(modulus);
    endfunction

endpackage

// File: rtl/updown_counter.sv
// Parametrised modulo-MODULUS up/down counter with clear, load, wrap or
// saturate ends, a combinational terminal count and sticky overflow.
module updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0]   ONE_EXT  = (WIDTH + 1)'(1);
    localparam bit               SAT_MODE = (SATURATE == CNT_SAT);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("updown_counter: WIDTH must be at least 1");
        end
        if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
            $error("updown_counter: MODULUS must lie in 2..2**WIDTH");
        end
        if (SATURATE != CNT_WRAP && SATURATE != CNT_SAT) begin : g_bad_mode
            $error("updown_counter: SATURATE must be CNT_WRAP or CNT_SAT");
        end
    endgenerate

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   count_ext;
    logic             at_max;
    logic             at_zero;

    // One extra bit keeps +1 correct when MODULUS fills the whole register.
    assign count_ext = {1'b0, count_q};
    assign at_max    = (count_q == MAX_VAL);
    assign at_zero   = (count_q == '0);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            if ({1'b0, load_val} < MOD_EXT) begin
                count_d = load_val;
            end else begin
                count_d = MAX_VAL;
                ovf_d   = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (!at_max) begin
                    count_d = WIDTH'(count_ext + ONE_EXT);
                end else if (SAT_MODE) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    count_d = WIDTH'(count_ext - ONE_EXT);
                end else if (SAT_MODE) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = MAX_VAL;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    // Combinational so a following stage can take it directly as its enable.
    assign tc    = en & ~clr & ~load & ((up & at_max) | (~up & at_zero));
    assign count = count_q;
    assign wrap  = wrap_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: wrap, saturate, power-of-two and cascaded
// instances checked every cycle against an integer model plus literal vectors.
module tb_updown_counter;

    typedef struct packed {
        logic       clr;
        logic       load;
        logic       en;
        logic       up;
        logic [3:0] lv;
    } in_t;

    typedef struct {
        int cnt;
        bit wrap;
        bit ovf;
    } st_t;

    logic clk = 1'b0;
    logic reset_n;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    in_t in_a, in_b, in_c, in_u;

    logic [3:0] cnt_a, cnt_b, cnt_u, cnt_t;
    logic [1:0] cnt_c;
    logic       tc_a, tc_b, tc_c, tc_u, tc_t;
    logic       wrap_a, wrap_b, wrap_c, wrap_u, wrap_t;
    logic       ovf_a, ovf_b, ovf_c, ovf_u, ovf_t;

    st_t m_a = '{cnt: 0, wrap: 0, ovf: 0};
    st_t m_b = '{cnt: 0, wrap: 0, ovf: 0};
    st_t m_c = '{cnt: 0, wrap: 0, ovf: 0};
    st_t m_u = '{cnt: 0, wrap: 0, ovf: 0};
    st_t m_t = '{cnt: 0, wrap: 0, ovf: 0};

    int seq1[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
    int seq2[10] = '{7, 6, 5, 4, 3, 2, 1, 0, 9, 8};
    int seq3[4]  = '{8, 9, 9, 9};
    int ovf3[4]  = '{0, 0, 1, 1};
    int seq5[6]  = '{0, 1, 2, 3, 0, 1};

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_a (
        .clk(clk), .reset_n(reset_n), .clr(in_a.clr), .load(in_a.load),
        .load_val(in_a.lv), .en(in_a.en), .up(in_a.up),
        .count(cnt_a), .tc(tc_a), .wrap(wrap_a), .ovf(ovf_a)
    );

    updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_b (
        .clk(clk), .reset_n(reset_n), .clr(in_b.clr), .load(in_b.load),
        .load_val(in_b.lv), .en(in_b.en), .up(in_b.up),
        .count(cnt_b), .tc(tc_b), .wrap(wrap_b), .ovf(ovf_b)
    );

    updown_counter #(.WIDTH(2), .MODULUS(4), .SATURATE(0)) u_c (
        .clk(clk), .reset_n(reset_n), .clr(in_c.clr), .load(in_c.load),
        .load_val(in_c.lv[1:0]), .en(in_c.en), .up(in_c.up),
        .count(cnt_c), .tc(tc_c), .wrap(wrap_c), .ovf(ovf_c)
    );

    updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_units (
        .clk(clk), .reset_n(reset_n), .clr(in_u.clr), .load(in_u.load),
        .load_val(in_u.lv), .en(in_u.en), .up(in_u.up),
        .count(cnt_u), .tc(tc_u), .wrap(wrap_u), .ovf(ovf_u)
    );

    updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_tens (
        .clk(clk), .reset_n(reset_n), .clr(in_u.clr), .load(in_u.load),
        .load_val(in_u.lv), .en(tc_u), .up(in_u.up),
        .count(cnt_t), .tc(tc_t), .wrap(wrap_t), .ovf(ovf_t)
    );

    // Next state from the rules in plain integer arithmetic.
    function automatic st_t model_step(st_t s, in_t i, bit en, int modv, bit sat);
        st_t n;
        int  t;
        n      = s;
        n.wrap = 1'b0;
        t      = i.up ? s.cnt + 1 : s.cnt - 1;
        if (i.clr) begin
            n.cnt = 0;
            n.ovf = 1'b0;
        end else if (i.load) begin
            if (int'(i.lv) < modv) begin
                n.cnt = int'(i.lv);
            end else begin
                n.cnt = modv - 1;
                n.ovf = 1'b1;
            end
        end else if (en) begin
            if (t >= 0 && t < modv) begin
                n.cnt = t;
            end else if (sat) begin
                n.ovf = 1'b1;
            end else begin
                n.cnt  = (t + modv) % modv;
                n.wrap = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic bit model_tc(st_t s, in_t i, bit en, int modv);
        return en && !i.clr && !i.load &&
               ((i.up && s.cnt == modv - 1) || (!i.up && s.cnt == 0));
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_a <= '{cnt: 0, wrap: 0, ovf: 0};
            m_b <= '{cnt: 0, wrap: 0, ovf: 0};
            m_c <= '{cnt: 0, wrap: 0, ovf: 0};
            m_u <= '{cnt: 0, wrap: 0, ovf: 0};
            m_t <= '{cnt: 0, wrap: 0, ovf: 0};
        end else begin
            m_a <= model_step(m_a, in_a, in_a.en, 10, 1'b0);
            m_b <= model_step(m_b, in_b, in_b.en, 10, 1'b1);
            m_c <= model_step(m_c, in_c, in_c.en, 4, 1'b0);
            m_u <= model_step(m_u, in_u, in_u.en, 10, 1'b0);
            m_t <= model_step(m_t, in_u, model_tc(m_u, in_u, in_u.en, 10), 10, 1'b0);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_count", cnt_a, m_a.cnt);
            check("a_wrap", wrap_a, m_a.wrap);
            check("a_ovf", ovf_a, m_a.ovf);
            check("a_tc", tc_a, model_tc(m_a, in_a, in_a.en, 10));
            check("b_count", cnt_b, m_b.cnt);
            check("b_wrap", wrap_b, m_b.wrap);
            check("b_ovf", ovf_b, m_b.ovf);
            check("b_tc", tc_b, model_tc(m_b, in_b, in_b.en, 10));
            check("c_count", cnt_c, m_c.cnt);
            check("c_wrap", wrap_c, m_c.wrap);
            check("c_ovf", ovf_c, m_c.ovf);
            check("c_tc", tc_c, model_tc(m_c, in_c, in_c.en, 4));
            check("units_count", cnt_u, m_u.cnt);
            check("units_wrap", wrap_u, m_u.wrap);
            check("units_tc", tc_u, model_tc(m_u, in_u, in_u.en, 10));
            check("tens_count", cnt_t, m_t.cnt);
            check("tens_wrap", wrap_t, m_t.wrap);
            check("tens_ovf", ovf_t, m_t.ovf);
            check("tens_tc", tc_t, model_tc(m_t, in_u, model_tc(m_u, in_u, in_u.en, 10), 10));
        end
    end

    task automatic step_cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        in_a    = '0;
        in_b    = '0;
        in_c    = '0;
        in_u    = '0;
        reset_n = 1'b0;
        step_cyc();
        step_cyc();
        check("reset_count", cnt_a, 0);
        check("reset_wrap", wrap_a, 0);
        check("reset_ovf", ovf_a, 0);
        chk_en  = 1'b1;
        reset_n = 1'b1;

        // Count up through the wrap.
        in_a.en = 1'b1;
        in_a.up = 1'b1;
        #1;
        for (int i = 0; i < 12; i++) begin
            check("t1_count", cnt_a, seq1[i]);
            check("t1_tc", tc_a, (i == 9));
            check("t1_wrap", wrap_a, (i == 10));
            step_cyc();
        end
        #2;
        reset_n = 1'b0;
        in_a.en = 1'b0;
        #1;
        check("t1_async_reset", cnt_a, 0);
        step_cyc();
        reset_n = 1'b1;

        // Load then count down through the wrap.
        in_a.load = 1'b1;
        in_a.lv   = 4'd7;
        step_cyc();
        in_a.load = 1'b0;
        in_a.en   = 1'b1;
        in_a.up   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("t2_count", cnt_a, seq2[i]);
            check("t2_wrap", wrap_a, (i == 8));
            step_cyc();
        end
        in_a.en = 1'b0;

        // Saturating instance holds at the top and flags overflow.
        in_b.load = 1'b1;
        in_b.lv   = 4'd8;
        step_cyc();
        in_b.load = 1'b0;
        in_b.en   = 1'b1;
        in_b.up   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t3_count", cnt_b, seq3[i]);
            check("t3_ovf", ovf_b, ovf3[i]);
            check("t3_wrap", wrap_b, 0);
            step_cyc();
        end
        in_b.en  = 1'b0;
        in_b.clr = 1'b1;
        step_cyc();
        check("t3_clr_count", cnt_b, 0);
        check("t3_clr_ovf", ovf_b, 0);
        in_b.clr = 1'b0;

        // Out-of-range load, load beating a terminal count, clear beating all.
        in_a.load = 1'b1;
        in_a.lv   = 4'd12;
        step_cyc();
        check("t4_oor_count", cnt_a, 9);
        check("t4_oor_ovf", ovf_a, 1);
        in_a.lv = 4'd3;
        in_a.en = 1'b1;
        in_a.up = 1'b1;
        #1;
        check("t4_load_tc", tc_a, 0);
        step_cyc();
        check("t4_load_count", cnt_a, 3);
        check("t4_load_wrap", wrap_a, 0);
        check("t4_ovf_sticky", ovf_a, 1);
        in_a.clr = 1'b1;
        in_a.lv  = 4'd5;
        step_cyc();
        check("t4_clr_count", cnt_a, 0);
        check("t4_clr_ovf", ovf_a, 0);
        in_a = '0;

        // Power-of-two modulus, then a direction change across zero.
        in_c.en = 1'b1;
        in_c.up = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("t5_count", cnt_c, seq5[i]);
            check("t5_wrap", wrap_c, (i == 4));
            if (i < 5) step_cyc();
        end
        in_c.up = 1'b0;
        step_cyc();
        check("t5_down_count", cnt_c, 0);
        step_cyc();
        check("t5_down_wrap_count", cnt_c, 3);
        check("t5_down_wrap", wrap_c, 1);
        in_c.en = 1'b0;

        // Two-digit cascade.
        in_u.en = 1'b1;
        in_u.up = 1'b1;
        repeat (25) step_cyc();
        check("t6_units", cnt_u, 5);
        check("t6_tens", cnt_t, 2);
        in_u.en   = 1'b0;
        in_u.load = 1'b1;
        in_u.lv   = 4'd9;
        step_cyc();
        check("t6_units_99", cnt_u, 9);
        check("t6_tens_99", cnt_t, 9);
        in_u.load = 1'b0;
        in_u.en   = 1'b1;
        #1;
        check("t6_tens_tc", tc_t, 1);
        step_cyc();
        check("t6_units_00", cnt_u, 0);
        check("t6_tens_00", cnt_t, 0);
        check("t6_tens_wrap", wrap_t, 1);
        in_u.en = 1'b0;

        step_cyc();
        step_cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised modulo-N up/down counter. It replaces the fixed 2-bit free-running counter as the general counting primitive for the lab designs, such as timers, dividers and digit counters. It adds:
- configurable width and modulus;
- direction control, enable, synchronous clear and parallel load;
- wrap or saturate mode;
- a cascade-ready terminal-count output.

## Interface
- `WIDTH`, default 4: counter width in bits, ≥1.
- `MODULUS`, default 10: count range is 0..MODULUS-1; 2 ≤ MODULUS ≤ 2^WIDTH.
- `SATURATE`, default 0: 0 selects wrap at the ends, 1 selects hold at the ends.
- `clk` input, 1 bit: rising-edge clock, the only clock.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `clr` input, 1 bit: synchronous clear to 0.
- `load` input, 1 bit: synchronous parallel load.
- `load_val` input, WIDTH bits: value to load.
- `en` input, 1 bit: count enable.
- `up` input, 1 bit: direction; 1 counts up, 0 counts down.
- `count` output, WIDTH bits: current count, registered.
- `tc` output, 1 bit: terminal count, combinational, for cascading.
- `wrap` output, 1 bit: one-cycle pulse after a wrap, registered.
- `ovf` output, 1 bit: sticky out-of-range flag, registered.

## Operation
- **Reset.** While `reset_n` = 0: `count` = 0, `wrap` = 0, `ovf` = 0, asynchronously. Release is synchronous to the next rising edge of `clk`.
- **Priority each cycle:** `clr` > `load` > `en` > hold.
- **`clr`.** Sets `count` = 0, `wrap` = 0 and `ovf` = 0.
- **`load`.** Sets `count` = `load_val` when `load_val` < MODULUS. Otherwise `count` = MODULUS-1 and `ovf` is set. `wrap` = 0.
- **`en`, counting up:**
  - `count` < MODULUS-1: increment.
  - At MODULUS-1 with SATURATE = 0: next value is 0 and `wrap` = 1.
  - At MODULUS-1 with SATURATE = 1: hold, and `ovf` is set.
- **`en`, counting down:**
  - `count` > 0: decrement.
  - At 0 with SATURATE = 0: next value is MODULUS-1 and `wrap` = 1.
  - At 0 with SATURATE = 1: hold, and `ovf` is set.
- **`tc`.** `tc` = `en` & !`clr` & !`load` & ((`up` & `count`==MODULUS-1) | (!`up` & `count`==0)). It is purely combinational, so the next stage can use it as its `en`.
- **Cascading.** Chaining `tc` into the next stage's `en` gives multi-digit counting with no added latency.
- **`wrap`.** High for exactly the one cycle after the wrapping edge. It is 0 in every other cycle, including holds and saturation.
- **`ovf`.** Once set, it stays set until `clr` or reset. `load` alone does not clear it.
- **Direction change.** `up` may change every cycle and takes effect on the same edge; no settling cycle is needed.
- **Arithmetic.** Internal next-state arithmetic is WIDTH+1 bits, so MODULUS = 2^WIDTH wraps correctly. The comparisons against MODULUS-1 use a WIDTH-bit constant.

## Timing
- `count` latency is 1 cycle from an edge with `clr`, `load` or `en` asserted.
- `tc` has zero latency, combinational from `count`, `en`, `up`, `clr` and `load`.
- `wrap` and `ovf` are updated on the same edge as the `count` transition that causes them.
- **Reset mid-count.** An asynchronous reset mid-count forces all outputs low immediately. The first count after release occurs on the first edge with `en` = 1.
- **Simultaneous events:**
  - `clr` with `load` and `en`: `clr` wins.
  - `load` with `en` at the terminal value: the load wins, with no wrap and no `ovf` from counting.
- **Held `en`.** With `en` held at 1 and SATURATE = 0, the period is exactly MODULUS cycles and `wrap` pulses once per period.

## Structure
- Shared package `counter_pkg` holds:
  - mode constants `CNT_WRAP` = 0 and `CNT_SAT` = 1;
  - a function for the minimum width for a modulus, for use by instantiating designs.
- Parameter checks (MODULUS range against WIDTH) go in an elaboration-time check block.
- No sub-module is needed. The block is one register set plus a next-state function.
- Multi-digit chains are built by instantiation at the top level, not inside this block.

## Test plan
Default parameters (WIDTH = 4, MODULUS = 10) unless noted.
1. Hold `reset_n` = 0 for 2 cycles, then `en` = 1, `up` = 1 for 12 cycles → `count` goes 0,1,…,9,0,1. `tc` is high while `count` = 9. `wrap` is high in the cycle `count` = 0 after 9. Assert `reset_n` = 0 mid-count → `count` = 0 immediately.
2. Load 7, then `en` = 1, `up` = 0 for 9 cycles → `count` goes 7,6,…,0,9,8. `wrap` pulses after the 0→9 step.
3. SATURATE = 1, `load_val` = 8, count up 3 cycles → `count` goes 8,9,9,9. `ovf` = 1 from the edge that holds at 9. Assert `clr` → `count` = 0, `ovf` = 0.
4. `load_val` = 12 (≥ MODULUS) → `count` = 9 and `ovf` = 1. Then `clr`, `load` and `en` together → `count` = 0, `ovf` = 0.
5. WIDTH = 2, MODULUS = 4, count up 5 cycles → `count` goes 0,1,2,3,0,1. This covers the power-of-two wrap.
6. Two cascaded instances (units `tc` → tens `en`), count up 25 cycles → tens = 2, units = 5. Tens wraps 9→0 only on a units terminal count.
